// File: rtl/store_buffer.sv
// Store buffer: holds stores from address calculation until ROB retirement,
// then drains them in order to data memory over a req/ack handshake.
module store_buffer #(
    parameter int DEPTH       = 4,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alloc_enable,
    input  logic [XLEN-1:0]        alloc_address,
    input  logic [XLEN-1:0]        alloc_data,
    input  logic [1:0]             alloc_size,
    input  logic [ROB_TAG_LEN-1:0] alloc_rob_tag,
    input  logic                   alloc_speculative,
    input  logic                   commit_valid,
    input  logic [ROB_TAG_LEN-1:0] commit_rob_tag,
    input  logic                   kill,
    input  logic                   resolve,
    input  logic                   mem_ack,
    output logic                   full,
    output logic                   empty,
    output logic                   pending_stores,
    output logic                   mem_req,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_data,
    output logic [1:0]             mem_size
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       committed_q;
    logic [DEPTH-1:0]       spec_q;
    logic [ROB_TAG_LEN-1:0] tag_q  [DEPTH];
    logic [XLEN-1:0]        addr_q [DEPTH];
    logic [XLEN-1:0]        data_q [DEPTH];
    logic [1:0]             size_q [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [PTR_W:0]   spec_count;

    state_t state_q;
    state_t state_d;
    logic   load;
    logic   pop;
    logic   alloc_fire;

    assign full           = (count_q == CNT_FULL);
    assign empty          = (count_q == '0);
    assign pending_stores = !empty;
    assign mem_req        = (state_q == REQ);
    assign alloc_fire     = alloc_enable && !full && !kill;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        spec_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            spec_count = spec_count + (PTR_W + 1)'(valid_q[i] & spec_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_q[head_q] && committed_q[head_q]) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Speculative entries are the youngest contiguous run, so kill only has to retract the count and tail.
    always_comb begin
        count_d = count_q;
        if (kill) begin
            count_d = count_q - spec_count;
        end else if (alloc_fire) begin
            count_d = count_q + CNT_ONE;
        end
        if (pop) begin
            count_d = count_d - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            committed_q <= '0;
            spec_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid && valid_q[i] && tag_q[i] == commit_rob_tag) begin
                    committed_q[i] <= 1'b1;
                    spec_q[i]      <= 1'b0;
                end
                if (resolve && !kill) begin
                    spec_q[i] <= 1'b0;
                end
                if (kill && valid_q[i] && spec_q[i]) begin
                    valid_q[i] <= 1'b0;
                    spec_q[i]  <= 1'b0;
                end
                if (pop && head_q == PTR_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end
                if (alloc_fire && tail_q == PTR_W'(i)) begin
                    valid_q[i]     <= 1'b1;
                    committed_q[i] <= 1'b0;
                    spec_q[i]      <= alloc_speculative && !resolve;
                end
            end
            if (pop) begin
                head_q <= head_q + PTR_ONE;
            end
            if (kill) begin
                tail_q <= head_q + PTR_W'(count_q - spec_count);
            end else if (alloc_fire) begin
                tail_q <= tail_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // NOTE: payload arrays carry no reset; valid_q alone decides whether an entry means anything.
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            tag_q[tail_q]  <= alloc_rob_tag;
            addr_q[tail_q] <= alloc_address;
            data_q[tail_q] <= alloc_data;
            size_q[tail_q] <= alloc_size;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mem_addr <= '0;
            mem_data <= '0;
            mem_size <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                mem_addr <= addr_q[head_q];
                mem_data <= data_q[head_q];
                mem_size <= size_q[head_q];
            end
        end
    end

endmodule
